// File: rtl/example_mac_pkg.sv
// Shared defaults and state enumeration for the example_mac_accum frame accumulator.
// The optional EXAMPLE_MAC_ACCUM_SAT_EN macro is consumed by example_mac_accum_round_sat.
package example_mac_pkg;

    localparam int DEF_IN_W       = 21;
    localparam int DEF_ACC_W      = 28;
    localparam int DEF_OUT_W      = 16;
    localparam int DEF_FRAC_SHIFT = 8;
    localparam int DEF_MAX_TERMS  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/example_mac_accum_round_sat.sv
// Round-half-up, then saturate (EXAMPLE_MAC_ACCUM_SAT_EN defined) or wrap (default) to OUT_W.
// ovf flags a clipped result, or a wrapped one whose discarded bits were not a sign extension.
module example_mac_accum_round_sat
    import example_mac_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] result,
    output logic                    ovf
);

    // One guard bit keeps the rounding add from overflowing at the top of the range.
    localparam int                  RND_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND   = (FRAC_SHIFT > 0) ? (ACC_W+1)'(1) << RND_POS : '0;
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((longint'(1) <<< (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-(longint'(1) <<< (OUT_W-1)));

    function automatic logic signed [ACC_W:0] round_half_up(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W:0] w;
        w = {s[ACC_W-1], s};
        w = w + RND;
        return w >>> FRAC_SHIFT;
    endfunction

    function automatic logic fits_out(input logic signed [ACC_W:0] r);
        return (r <= MAX_V) && (r >= MIN_V);
    endfunction

`ifdef EXAMPLE_MAC_ACCUM_SAT_EN
    function automatic logic signed [OUT_W-1:0] limit_out(input logic signed [ACC_W:0] r);
        if (r > MAX_V)
            return MAX_V[OUT_W-1:0];
        else if (r < MIN_V)
            return MIN_V[OUT_W-1:0];
        else
            return r[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] limit_out(input logic signed [ACC_W:0] r);
        return r[OUT_W-1:0];
    endfunction
`endif

    logic signed [ACC_W:0] rounded_p0;

    always_comb begin
        rounded_p0 = round_half_up(sum);
        ovf        = !fits_out(rounded_p0);
        result     = limit_out(rounded_p0);
    end

endmodule

// File: rtl/example_mac_accum.sv
// Frame accumulator: sums signed products until in_last or MAX_TERMS, then presents a rounded result.
// Define EXAMPLE_MAC_ACCUM_SAT_EN to saturate the result instead of wrapping it.
module example_mac_accum
    import example_mac_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int MAX_TERMS  = DEF_MAX_TERMS
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    out_err
);

    localparam int                CNT_W   = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          count;

    logic                      in_xfer;
    logic                      out_xfer;
    logic signed [ACC_W-1:0]   term_p0;
    logic signed [ACC_W-1:0]   sum_p0;
    logic [CNT_W-1:0]          count_p0;
    logic                      at_max_p0;
    logic                      close_p0;
    logic signed [OUT_W-1:0]   result_p0;
    logic                      ovf_p0;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Anything other than ACCUM starts a fresh frame, so a term arriving while
    // the previous result leaves HOLD is summed from zero.
    always_comb begin
        term_p0   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
        sum_p0    = (state == ST_ACCUM) ? acc + term_p0 : term_p0;
        count_p0  = (state == ST_ACCUM) ? count + 1'b1 : CNT_W'(1);
        at_max_p0 = (count_p0 == MAX_CNT);
        close_p0  = in_last || at_max_p0;
    end

    example_mac_accum_round_sat #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .sum    (sum_p0),
        .result (result_p0),
        .ovf    (ovf_p0)
    );

    // ---- stage p1: frame state and registered result ----
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else if (in_xfer) begin
            if (close_p0) begin
                state     <= ST_HOLD;
                acc       <= '0;
                count     <= '0;
                out_valid <= 1'b1;
                out_data  <= result_p0;
                out_ovf   <= ovf_p0;
                out_err   <= !in_last && at_max_p0;
            end else begin
                state     <= ST_ACCUM;
                acc       <= sum_p0;
                count     <= count_p0;
                out_valid <= 1'b0;
            end
        end else if (out_xfer) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_example_mac_accum.sv
// Self-checking bench for example_mac_accum: directed scenarios plus a randomized run
// against a frame-level arithmetic model.
module tb_example_mac_accum;

    localparam int IN_W  = 21;
    localparam int ACC_W = 28;
    localparam int OUT_W = 16;
    localparam int FRAC  = 8;
    localparam int MAXT  = 64;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data = '0;
    logic                    in_last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_ovf;
    logic                    out_err;

    int checks = 0;
    int errors = 0;

    example_mac_accum #(
        .IN_W       (IN_W),
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC),
        .MAX_TERMS  (MAXT)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference: rounded, then saturated or wrapped frame sum.
    task automatic model_result(input longint s, output longint d, output bit o);
        longint r;
        longint lim_hi;
        longint lim_lo;
        lim_hi = (longint'(1) << (OUT_W-1)) - 1;
        lim_lo = -(longint'(1) << (OUT_W-1));
        r = (s + (longint'(1) << (FRAC-1))) >>> FRAC;
        o = (r > lim_hi) || (r < lim_lo);
`ifdef EXAMPLE_MAC_ACCUM_SAT_EN
        if (r > lim_hi)      d = lim_hi;
        else if (r < lim_lo) d = lim_lo;
        else                 d = r;
`else
        d = ((r % 65536) + 65536) % 65536;
        if (d >= 32768) d = d - 65536;
`endif
    endtask

    // Presents one term and waits (bounded) until it is accepted; returns at edge+1.
    task automatic send_term(input int d, input bit l);
        int waited;
        in_valid = 1'b1;
        in_data  = IN_W'(d);
        in_last  = l;
        #1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge ap_clk);
            #2;
            waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b data=%0d ovf=%0b err=%0b required 0 0 0 0",
                     out_valid, out_data, out_ovf, out_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_basic();
        send_term(1000, 1'b0);
        send_term(2000, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %0b required 0", out_valid);
        end
        send_term(-500, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd10 || out_ovf !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: valid=%0b data=%0d ovf=%0b err=%0b required 1 10 0 0",
                     out_valid, out_data, out_ovf, out_err);
        end
        @(posedge ap_clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_max_terms();
        logic signed [OUT_W-1:0] exp_d;
`ifdef EXAMPLE_MAC_ACCUM_SAT_EN
        exp_d = 16'sd32767;
`else
        exp_d = 16'sd0;
`endif
        for (int i = 0; i < MAXT; i++) begin
            send_term(1048575, 1'b0);
            if (i == MAXT-2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL max_early_close: valid=%0b after %0d terms required 0", out_valid, i+1);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d || out_ovf !== 1'b1 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL max_terms_result: valid=%0b data=%0d ovf=%0b err=%0b required 1 %0d 1 1",
                     out_valid, out_data, out_ovf, out_err, exp_d);
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_neg_full();
        logic signed [OUT_W-1:0] exp_d;
`ifdef EXAMPLE_MAC_ACCUM_SAT_EN
        exp_d = -16'sd32768;
`else
        exp_d = 16'sd0;
`endif
        for (int i = 0; i < MAXT; i++)
            send_term(-1048576, i == MAXT-1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d || out_ovf !== 1'b1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL neg_full_result: valid=%0b data=%0d ovf=%0b err=%0b required 1 %0d 1 0",
                     out_valid, out_data, out_ovf, out_err, exp_d);
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_back_to_back();
        send_term(1000, 1'b0);
        send_term(2000, 1'b0);
        out_ready = 1'b0;
        send_term(-500, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'sd10) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d in_ready=%0b valid=%0b data=%0d required 0 1 10",
                         i, in_ready, out_valid, out_data);
            end
            @(posedge ap_clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = IN_W'(300);
        in_last   = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %0b required 1", in_ready);
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL concurrent_result: valid=%0b data=%0d err=%0b required 1 1 0",
                     out_valid, out_data, out_err);
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            send_term(5000, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: valid=%0b data=%0d ovf=%0b err=%0b required 0 0 0 0",
                     out_valid, out_data, out_ovf, out_err);
        end
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        send_term(256, 1'b0);
        send_term(256, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd2) begin
            errors++;
            $display("FAIL reset_mid_frame: valid=%0b data=%0d required 1 2", out_valid, out_data);
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_random();
        bit      m_vld = 1'b0;
        longint  m_data = 0;
        bit      m_ovf = 1'b0;
        bit      m_err = 1'b0;
        longint  m_sum = 0;
        int      m_cnt = 0;
        int      v;
        bit      exp_rdy;
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if (out_valid !== m_vld) begin
                errors++;
                $display("FAIL rand_valid: cycle %0d got %0b required %0b", cyc, out_valid, m_vld);
            end else if (m_vld) begin
                checks++;
                if (longint'(out_data) != m_data || out_ovf !== m_ovf || out_err !== m_err) begin
                    errors++;
                    $display("FAIL rand_result: cycle %0d data=%0d ovf=%0b err=%0b required %0d %0b %0b",
                             cyc, out_data, out_ovf, out_err, m_data, m_ovf, m_err);
                end
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                v = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W-1));
            else
                v = int'($urandom_range(0, 4000)) - 2000;
            in_data = IN_W'(v);
            #1;
            exp_rdy = !m_vld || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_in_ready: cycle %0d got %0b required %0b", cyc, in_ready, exp_rdy);
            end
            if (m_vld && out_ready)
                m_vld = 1'b0;
            if (in_valid && exp_rdy) begin
                m_sum += v;
                m_cnt++;
                if (in_last || m_cnt == MAXT) begin
                    model_result(m_sum, m_data, m_ovf);
                    m_err = !in_last;
                    m_vld = 1'b1;
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            @(posedge ap_clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        @(posedge ap_clk);
        #1;
        test_reset();
        test_basic();
        test_max_terms();
        test_neg_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
